// File: rtl/balanced_adder_pkg.sv
// Package: balanced_adder_pkg
// Shared helpers for the balanced pipelined adder family.
//   stages(width, bps)       : number of pipeline stages (one per bit group)
//   latency(width, bps)      : accept-to-result latency in advancing cycles
//   params_legal(width, bps) : WIDTH/BITS_PER_STAGE legality rule
package balanced_adder_pkg;

  function automatic int stages(input int width, input int bps);
    return width / bps;
  endfunction

  // Every path crosses exactly one register per stage, so latency equals stage count.
  function automatic int latency(input int width, input int bps);
    return stages(width, bps);
  endfunction

  function automatic bit params_legal(input int width, input int bps);
    return (width >= 32'sd2) && (bps >= 32'sd1) && (bps <= width) &&
           ((width % bps) == 32'sd0);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// Module: adder_stage
// One BPS-wide ripple-carry slice with registered outputs.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : pipeline advance; registers hold when low
//   a, b       : operand slices (b already conditioned for subtract)
//   cin        : carry into the slice LSB
//   sum        : registered sum slice
//   cout       : registered carry out of the slice MSB
//   cmsb       : registered carry into the slice MSB (signed-overflow term)
module adder_stage #(
  parameter int BPS = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [BPS-1:0] a,
  input  logic [BPS-1:0] b,
  input  logic           cin,
  output logic [BPS-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [BPS:0]   carry_s;
  logic [BPS-1:0] sum_s;

  // Ripple the slice bit by bit from the incoming carry.
  always_comb begin
    carry_s    = '0;
    sum_s      = '0;
    carry_s[0] = cin;
    for (int i = 0; i < BPS; i++) begin
      sum_s[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
  end

  // Slice result registers; advance only with the rest of the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      cmsb <= 1'b0;
    end else if (en) begin
      sum  <= sum_s;
      cout <= carry_s[BPS];
      cmsb <= carry_s[BPS-1];
    end
  end

endmodule

// File: rtl/pipelined_balanced_adder.sv
// Module: pipelined_balanced_adder
// WIDTH-bit add/subtract unit built as a pipelined ripple-carry adder in which every
// input-to-output path crosses STAGES registers. Operand groups are skewed into their
// stage; sum groups are de-skewed so one beat's slices leave together.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand stream handshake (in_ready = advance, combinational)
//   a, b, cin, sub      : operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready : result stream handshake
//   sum, cout, ovf      : result mod 2^WIDTH, carry out of MSB, signed overflow
module pipelined_balanced_adder
  import balanced_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int BPS    = BITS_PER_STAGE;
  localparam int STAGES = stages(WIDTH, BITS_PER_STAGE);

  if (!params_legal(WIDTH, BITS_PER_STAGE)) begin : g_bad_params
    $error("pipelined_balanced_adder: WIDTH must be >= 2 and divisible by BITS_PER_STAGE");
  end

  logic                         adv_s;
  logic [STAGES-1:0]            valid_r;
  logic [STAGES-1:0][BPS-1:0]   a_grp_s;
  logic [STAGES-1:0][BPS-1:0]   b_grp_s;
  logic [STAGES-1:0]            sub_grp_s;
  logic [STAGES-1:0]            cin_grp_s;
  logic [STAGES-1:0][BPS-1:0]   stage_sum_r;
  logic [STAGES-1:0]            cout_r;
  logic [STAGES-1:0]            cmsb_r;
  logic [STAGES-1:0][BPS-1:0]   sum_out_s;
  logic                         unused_cmsb_s;

  // The whole pipe moves as one; a stalled result blocks everything behind it.
  assign adv_s     = ~out_valid | out_ready;
  assign in_ready  = adv_s;
  assign out_valid = valid_r[STAGES-1];

  // Valid shift chain; bubbles travel as invalid slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
    end else if (adv_s) begin
      valid_r[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_r[k] <= valid_r[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    localparam int DESKEW = STAGES - 1 - k;
    logic [BPS-1:0] b_eff_s;

    // Input skew: group k (and its sub bit) waits k cycles to meet its carry.
    if (k == 0) begin : g_no_skew
      assign a_grp_s[k]   = a[BPS-1:0];
      assign b_grp_s[k]   = b[BPS-1:0];
      assign sub_grp_s[k] = sub;
      assign cin_grp_s[k] = sub ? 1'b1 : cin;
    end else begin : g_skew
      logic [BPS-1:0] a_line_r [k];
      logic [BPS-1:0] b_line_r [k];
      logic [k-1:0]   sub_line_r;

      // Operand skew line for this group.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < k; i++) begin
            a_line_r[i] <= '0;
            b_line_r[i] <= '0;
          end
          sub_line_r <= '0;
        end else if (adv_s) begin
          a_line_r[0]   <= a[k*BPS +: BPS];
          b_line_r[0]   <= b[k*BPS +: BPS];
          sub_line_r[0] <= sub;
          for (int i = 1; i < k; i++) begin
            a_line_r[i]   <= a_line_r[i-1];
            b_line_r[i]   <= b_line_r[i-1];
            sub_line_r[i] <= sub_line_r[i-1];
          end
        end
      end

      assign a_grp_s[k]   = a_line_r[k-1];
      assign b_grp_s[k]   = b_line_r[k-1];
      assign sub_grp_s[k] = sub_line_r[k-1];
      assign cin_grp_s[k] = cout_r[k-1];
    end

    // Subtract adds ~b; the +1 enters as stage-0 carry-in.
    assign b_eff_s = sub_grp_s[k] ? ~b_grp_s[k] : b_grp_s[k];

    adder_stage #(.BPS(BPS)) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (adv_s),
      .a    (a_grp_s[k]),
      .b    (b_eff_s),
      .cin  (cin_grp_s[k]),
      .sum  (stage_sum_r[k]),
      .cout (cout_r[k]),
      .cmsb (cmsb_r[k])
    );

    // Output de-skew: early groups wait for the last stage to catch up.
    if (DESKEW == 0) begin : g_no_deskew
      assign sum_out_s[k] = stage_sum_r[k];
    end else begin : g_deskew
      logic [BPS-1:0] deskew_r [DESKEW];

      // Sum de-skew line for this group.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DESKEW; i++) begin
            deskew_r[i] <= '0;
          end
        end else if (adv_s) begin
          deskew_r[0] <= stage_sum_r[k];
          for (int i = 1; i < DESKEW; i++) begin
            deskew_r[i] <= deskew_r[i-1];
          end
        end
      end

      assign sum_out_s[k] = deskew_r[DESKEW-1];
    end
  end

  // Only the last stage's carry-into-MSB feeds overflow; earlier ones are inert.
  assign unused_cmsb_s = ^cmsb_r;

  assign sum  = sum_out_s;
  assign cout = cout_r[STAGES-1];
  assign ovf  = cmsb_r[STAGES-1] ^ cout_r[STAGES-1];

endmodule
